// File: rtl/jt1942_obj_pkg.sv
// Shared types and constants for the 1942 object scan scheduler.
package jt1942_obj_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CHECK = 3'd2,
        PUSH  = 3'd3,
        NEXT  = 3'd4
    } state_t;

    localparam int OBJBYTES = 4;

    localparam logic [1:0] B_CODE = 2'd0;
    localparam logic [1:0] B_ATTR = 2'd1;
    localparam logic [1:0] B_Y    = 2'd2;
    localparam logic [1:0] B_X    = 2'd3;

    // Attribute byte: {code[8], vflip, hflip, x[8], pal[3:0]}
    localparam int A_CODE8  = 7;
    localparam int A_VFLIP  = 6;
    localparam int A_HFLIP  = 5;
    localparam int A_X8     = 4;
    localparam int A_PAL_HI = 3;
    localparam int A_PAL_LO = 0;

endpackage

// File: rtl/jt1942_objmatch.sv
// Registered vertical hit test: an object covers line V when (V - y) mod 256 < 16.
module jt1942_objmatch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [7:0] i_v,
    input  logic [7:0] i_y,
    input  logic       i_vflip,
    output logic       o_hit,
    output logic [3:0] o_vsub
);

    logic [7:0] w_d;
    logic       r_hit;
    logic [3:0] r_vsub;

    assign w_d = i_v - i_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit  <= 1'b0;
            r_vsub <= 4'd0;
        end else if (i_en) begin
            r_hit  <= (w_d[7:4] == 4'd0);
            r_vsub <= w_d[3:0] ^ {4{i_vflip}};
        end
    end

    assign o_hit  = r_hit;
    assign o_vsub = r_vsub;

endmodule

// File: rtl/jt1942_objsched.sv
// Per-line object RAM scanner and CPU/scan port arbiter for the 1942 sprite path.
// Optional per-line push limit enabled by defining JT1942_OBJSCHED_LIMIT_EN.
module jt1942_objsched
    import jt1942_obj_pkg::*;
#(
    parameter int OBJMAX     = 32,
    parameter int OBJPERLINE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen6,
    input  logic       HINIT,
    input  logic [7:0] V,
    input  logic       cpu_req,
    input  logic [6:0] cpu_addr,
    output logic       cpu_wait,
    output logic [6:0] ram_addr,
    input  logic [7:0] ram_dout,
    output logic       obj_valid,
    input  logic       obj_ready,
    output logic [8:0] obj_code,
    output logic [3:0] obj_pal,
    output logic       obj_hflip,
    output logic [8:0] obj_x,
    output logic [3:0] obj_vsub,
    output logic       busy,
    output logic       line,
    output logic       overrun
);

    localparam logic [4:0] LAST_IDX = 5'(OBJMAX - 1);

    state_t     r_state, w_next;
    logic [4:0] r_idx;
    logic [1:0] r_byte;
    logic       r_have;
    logic [7:0] r_code_lo, r_attr, r_y, r_xlo;
    logic       r_line, r_overrun;
    logic [8:0] r_obj_code, r_obj_x;
    logic [3:0] r_obj_pal, r_obj_vsub;
    logic       r_obj_hflip;
    logic       w_fetch_done, w_hit, w_take;
    logic [3:0] w_vsub;
    logic [1:0] w_slot;

    // Data for the address presented last cen6 is on ram_dout now.
    assign w_slot       = r_byte - 2'd1;
    assign w_fetch_done = (r_state == FETCH) && r_have && (r_byte == B_CODE);

    jt1942_objmatch u_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (cen6 && w_fetch_done),
        .i_v     (V),
        .i_y     (r_y),
        .i_vflip (r_attr[A_VFLIP]),
        .o_hit   (w_hit),
        .o_vsub  (w_vsub)
    );

`ifdef JT1942_OBJSCHED_LIMIT_EN
    localparam int HW = $clog2(OBJPERLINE + 1);
    logic [HW-1:0] r_hits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hits <= '0;
        end else if (cen6) begin
            if (HINIT)
                r_hits <= '0;
            else if (r_state == PUSH && obj_ready)
                r_hits <= r_hits + HW'(1);
        end
    end

    assign w_take = w_hit && (r_hits < HW'(OBJPERLINE));
`else
    logic w_unused_limit;
    assign w_unused_limit = (OBJPERLINE != 0);
    assign w_take         = w_hit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else if (cen6)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (HINIT) begin
            w_next = FETCH;
        end else begin
            case (r_state)
                IDLE:    w_next = IDLE;
                FETCH:   if (w_fetch_done) w_next = CHECK;
                CHECK:   w_next = w_take ? PUSH : NEXT;
                PUSH:    if (obj_ready) w_next = NEXT;
                NEXT:    w_next = (r_idx == LAST_IDX) ? IDLE : FETCH;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state != IDLE);
        cpu_wait  = busy && cpu_req;
        ram_addr  = busy ? {r_idx, r_byte} : cpu_addr;
        obj_valid = (r_state == PUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= 5'd0;
            r_byte      <= 2'd0;
            r_have      <= 1'b0;
            r_code_lo   <= 8'd0;
            r_attr      <= 8'd0;
            r_y         <= 8'd0;
            r_xlo       <= 8'd0;
            r_line      <= 1'b0;
            r_overrun   <= 1'b0;
            r_obj_code  <= 9'd0;
            r_obj_x     <= 9'd0;
            r_obj_pal   <= 4'd0;
            r_obj_vsub  <= 4'd0;
            r_obj_hflip <= 1'b0;
        end else if (cen6) begin
            if (HINIT) begin
                r_idx     <= 5'd0;
                r_byte    <= 2'd0;
                r_have    <= 1'b0;
                r_line    <= ~r_line;
                r_overrun <= (r_state != IDLE);
            end else begin
                case (r_state)
                    FETCH: begin
                        r_byte <= r_byte + 2'd1;
                        r_have <= 1'b1;
                        if (r_have) begin
                            case (w_slot)
                                B_CODE:  r_code_lo <= ram_dout;
                                B_ATTR:  r_attr    <= ram_dout;
                                B_Y:     r_y       <= ram_dout;
                                default: r_xlo     <= ram_dout;
                            endcase
                        end
                    end
                    CHECK: begin
                        if (w_take) begin
                            r_obj_code  <= {r_attr[A_CODE8], r_code_lo};
                            r_obj_pal   <= r_attr[A_PAL_HI:A_PAL_LO];
                            r_obj_hflip <= r_attr[A_HFLIP];
                            r_obj_x     <= {r_attr[A_X8], r_xlo};
                            r_obj_vsub  <= w_vsub;
                        end
                    end
                    NEXT: begin
                        r_idx  <= r_idx + 5'd1;
                        r_byte <= 2'd0;
                        r_have <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign obj_code  = r_obj_code;
    assign obj_pal   = r_obj_pal;
    assign obj_hflip = r_obj_hflip;
    assign obj_x     = r_obj_x;
    assign obj_vsub  = r_obj_vsub;
    assign line      = r_line;
    assign overrun   = r_overrun;

endmodule

// File: doc/jt1942_objsched.md
Name: jt1942_objsched

Overview:
- Per-line object scan scheduler for the 1942 sprite path.
- On every HINIT it walks the 32-entry object RAM (4 bytes/object) and fetches each entry.
- Tests vertical hit against the current V and hands matching objects to the object drawer over a valid/ready handshake.
- Also arbitrates the single object-RAM port between the scan and the CPU; it sits between main-CPU object RAM and the drawer/line buffer.

Parameters:
- OBJMAX, 32, objects scanned per line (power of two, ≤32)
- OBJPERLINE, 8, max objects pushed per line (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cen6  in  1  6 MHz clock enable; all state advances only when cen6=1
- HINIT  in  1  line start strobe (sampled with cen6)
- V  in  8  current vertical line
- cpu_req  in  1  CPU object-RAM access request
- cpu_addr  in  7  CPU object-RAM address
- cpu_wait  out  1  CPU stall: cpu_req AND port owned by scan
- ram_addr  out  7  object-RAM address (combinational mux)
- ram_dout  in  8  object-RAM data, valid one cen6 after ram_addr
- obj_valid  out  1  object entry available
- obj_ready  in  1  drawer accepts entry
- obj_code  out  9  tile code
- obj_pal  out  4  palette
- obj_hflip  out  1  horizontal flip
- obj_x  out  9  horizontal position
- obj_vsub  out  4  row inside 16-pixel object, vflip applied
- busy  out  1  scan in progress
- line  out  1  line-buffer bank select, toggles on each HINIT
- overrun  out  1  sticky per line: HINIT arrived before scan finished

Behaviour:
- Reset (rst_n=0, async): state IDLE, obj_valid=0, all obj_* = 0, busy=0, line=0, overrun=0, cpu_wait=0, object index=0.
- Byte layout per object n at addresses 4n..4n+3:
  - b0 = code[7:0]
  - b1 = {code[8], vflip, hflip, x[8], pal[3:0]}
  - b2 = y
  - b3 = x[7:0]
- FSM states and transitions (all on cen6):
  - IDLE → FETCH on HINIT (index=0, byte=0, overrun cleared, line toggled).
  - FETCH: drive address 4·index+byte. Each data byte is captured one cen6 after its address, so a full entry takes 5 cen6.
  - FETCH → CHECK after b3 is captured.
  - CHECK: d = (V − y) mod 256. Hit when d[7:4]==0. obj_vsub = d[3:0] XOR {4{vflip}}.
  - CHECK → PUSH on hit, else NEXT.
  - PUSH: obj_valid=1 with fields stable until the cycle where obj_valid & obj_ready & cen6. Then obj_valid=0 → NEXT.
  - NEXT: index+1; if index==OBJMAX−1 → IDLE, else → FETCH.
- busy=1 in every state except IDLE.
- Arbitration: in IDLE, ram_addr=cpu_addr and cpu_wait=0. Otherwise ram_addr=scan address and cpu_wait=cpu_req. The CPU is never granted mid-object.
- HINIT while busy: abort the current entry, drop obj_valid immediately, set overrun=1, toggle line, restart at index 0. Overrun stays set until the next HINIT that finds the FSM in IDLE.
- Index arithmetic: 5-bit, wraps; byte counter is 2-bit.
- A pending drawer stall (obj_ready=0) holds the FSM in PUSH indefinitely; only HINIT or reset exits.

Optional Feature:
- Macro: JT1942_OBJSCHED_LIMIT_EN.
- Defined: a per-line hit counter counts accepted pushes. Once it reaches OBJPERLINE, further hits are discarded (CHECK → NEXT), the scan still completes, and the counter clears on HINIT.
- Undefined: all hits are pushed, OBJPERLINE is ignored, and no counter exists.

Decomposition:
- Package jt1942_obj_pkg holds:
  - state enum (IDLE, FETCH, CHECK, PUSH, NEXT)
  - OBJBYTES=4
  - byte offsets B_CODE=0, B_ATTR=1, B_Y=2, B_X=3
  - attr bit positions
- One sub-module, jt1942_objmatch: registered vertical compare producing hit and obj_vsub from V, y and vflip.

Test Plan:
- Reset mid-PUSH with obj_valid=1 → all outputs 0 immediately, busy=0, line=0.
- Object 3 with y=0x40, V=0x45, vflip=0, obj_ready=1, all other y=0xF0 → exactly one push: obj_vsub=5, code/x/pal match RAM. Scan ends with busy=0 after 32 entries.
- Same as above with vflip=1 → obj_vsub=0xA. With y=0xF8, V=0x03 (wrap) → hit, vsub=0xB.
- obj_ready held 0 for 20 cen6 on first hit → obj_valid and fields stable throughout; scan resumes on the cycle ready rises.
- cpu_req=1 during scan → cpu_wait=1 and ram_addr follows scan. After IDLE is entered → cpu_wait=0 and ram_addr=cpu_addr.
- HINIT at index 10 → overrun=1, line toggles, restart from index 0. With JT1942_OBJSCHED_LIMIT_EN and 12 hitting objects → exactly 8 pushes.
